butterfly_fft32: RTL and testbench

BUTTERFLY_FFT32 -- requirements
Module: butterfly

---
 rtl/butterfly_fft32.sv | 119 +++++++++++
 tb/tb_butterfly_fft32.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/butterfly_fft32.sv
// 32-point radix-2 decimation-in-time FFT on Q16.16 complex samples, one frame per clock, 28-cycle latency.
// Optional build macro BUTTERFLY_STAGE_SCALE_EN halves every butterfly output, giving out = DFT/32.
module butterfly_fft32 (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] inp,
  output logic [2047:0] out
);

  localparam int NumStages  = 5;
  localparam int DelayDepth = 21;

`ifdef BUTTERFLY_STAGE_SCALE_EN
  localparam int OutShift = 1;
`else
  localparam int OutShift = 0;
`endif

  // Quarter-wave cosine table: round(65536 * cos(2*pi*m/32)) for m = 0..8.
  function automatic logic signed [31:0] quarterCos(input int m);
    logic signed [31:0] c;
    case (m)
      0:       c = 32'sd65536;
      1:       c = 32'sd64277;
      2:       c = 32'sd60547;
      3:       c = 32'sd54491;
      4:       c = 32'sd46341;
      5:       c = 32'sd36410;
      6:       c = 32'sd25080;
      7:       c = 32'sd12785;
      default: c = 32'sd0;
    endcase
    return c;
  endfunction

  function automatic logic signed [31:0] twiddleRe(input int k);
    return (k <= 8) ? quarterCos(k) : -quarterCos(16 - k);
  endfunction

  function automatic logic signed [31:0] twiddleIm(input int k);
    return (k <= 8) ? -quarterCos(8 - k) : -quarterCos(k - 8);
  endfunction

  function automatic logic signed [31:0] mulQ(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return 32'((longint'(a) * longint'(b)) >>> 16);
  endfunction

  function automatic logic [2047:0] bitRevFrame(input logic [2047:0] x);
    logic [2047:0] r;
    logic [4:0]    n5;
    logic [4:0]    rv;
    r = '0;
    for (int n = 0; n < 32; n++) begin
      n5 = 5'(n);
      rv = {n5[0], n5[1], n5[2], n5[3], n5[4]};
      r[64*int'(rv) +: 64] = x[64*n +: 64];
    end
    return r;
  endfunction

  // Stage s pairs elements a span of 2^s apart; twiddle index steps by 16/2^s within a group.
  function automatic logic [2047:0] bflyStage(input logic [2047:0] v, input int s);
    logic [2047:0]      r;
    int                 h;
    int                 top;
    int                 bot;
    int                 tw;
    logic signed [31:0] ar, ai, br, bi, wr, wi, tr, ti;
    logic signed [31:0] sr, si, dr, di;
    r = '0;
    h = 1 << s;
    for (int b = 0; b < 16; b++) begin
      top = (b / h) * 2 * h + (b % h);
      bot = top + h;
      tw  = (b % h) << (4 - s);
      ar  = v[64*top+32 +: 32];
      ai  = v[64*top    +: 32];
      br  = v[64*bot+32 +: 32];
      bi  = v[64*bot    +: 32];
      wr  = twiddleRe(tw);
      wi  = twiddleIm(tw);
      tr  = mulQ(wr, br) - mulQ(wi, bi);
      ti  = mulQ(wr, bi) + mulQ(wi, br);
      sr  = (ar + tr) >>> OutShift;
      si  = (ai + ti) >>> OutShift;
      dr  = (ar - tr) >>> OutShift;
      di  = (ai - ti) >>> OutShift;
      r[64*top +: 64] = {sr, si};
      r[64*bot +: 64] = {dr, di};
    end
    return r;
  endfunction

  logic [2047:0] stageReg  [0:NumStages];
  logic [2047:0] stageNext [0:NumStages-1];
  logic [2047:0] delayReg  [0:DelayDepth-1];

  for (genvar s = 0; s < NumStages; s++) begin : gStage
    assign stageNext[s] = bflyStage(stageReg[s], s);
  end

  // Input register, one register per butterfly stage, then a delay line so the
  // chain is exactly 28 registers deep including out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NumStages; i++) stageReg[i] <= '0;
      for (int i = 0; i < DelayDepth; i++) delayReg[i] <= '0;
      out <= '0;
    end else begin
      stageReg[0] <= bitRevFrame(inp);
      for (int i = 1; i <= NumStages; i++) stageReg[i] <= stageNext[i-1];
      delayReg[0] <= stageReg[NumStages];
      for (int i = 1; i < DelayDepth; i++) delayReg[i] <= delayReg[i-1];
      out <= delayReg[DelayDepth-1];
    end
  end

endmodule

// File: tb/tb_butterfly_fft32.sv
// Testbench for butterfly_fft32: floating-point DFT reference with a latency scoreboard.
// Honours BUTTERFLY_STAGE_SCALE_EN by scaling the reference by 1/32.
module tb_butterfly_fft32;

  logic          clk;
  logic          reset;
  logic [2047:0] inp;
  logic [2047:0] out;

  typedef struct {
    logic [2047:0] frame;
    int            tol;
    string         tag;
  } sbEntry_t;

  sbEntry_t scoreboard [$];
  int vectors     = 0;
  int miscompares = 0;

  localparam real Pi = 3.14159265358979323846;
`ifdef BUTTERFLY_STAGE_SCALE_EN
  localparam real OutScale = 1.0 / 32.0;
`else
  localparam real OutScale = 1.0;
`endif

  butterfly_fft32 dut (
    .clk  (clk),
    .reset(reset),
    .inp  (inp),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2047:0] setSample(input logic [2047:0] f, input int n,
                                              input logic [31:0] re, input logic [31:0] im);
    f[64*n +: 64] = {re, im};
    return f;
  endfunction

  function automatic logic [2047:0] randFrame();
    logic [2047:0] f;
    int v;
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(4096, 0)) - 2048;
      f[32*i +: 32] = 32'(v);
    end
    return f;
  endfunction

  // Reference transform in double precision, rounded to nearest and wrapped to 32 bits.
  function automatic logic [2047:0] dftModel(input logic [2047:0] x);
    logic [2047:0]      r;
    logic signed [31:0] fr, fi;
    real                re, im, xr, xi, ang, c, s;
    longint             qr, qi;
    for (int k = 0; k < 32; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 32; n++) begin
        fr  = x[64*n+32 +: 32];
        fi  = x[64*n    +: 32];
        xr  = $itor(fr);
        xi  = $itor(fi);
        ang = 2.0 * Pi * $itor((n * k) % 32) / 32.0;
        c   = $cos(ang);
        s   = $sin(ang);
        re  = re + xr * c + xi * s;
        im  = im + xi * c - xr * s;
      end
      qr = longint'(re * OutScale);
      qi = longint'(im * OutScale);
      r[64*k+32 +: 32] = qr[31:0];
      r[64*k    +: 32] = qi[31:0];
    end
    return r;
  endfunction

  function automatic longint absL(input logic signed [31:0] v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  task automatic checkOutput();
    sbEntry_t           e;
    longint             worst;
    int                 worstBin;
    logic signed [31:0] dr, di;
    if (scoreboard.size() < 28) return;
    e        = scoreboard.pop_front();
    worst    = 0;
    worstBin = 0;
    for (int k = 0; k < 32; k++) begin
      dr = out[64*k+32 +: 32] - e.frame[64*k+32 +: 32];
      di = out[64*k    +: 32] - e.frame[64*k    +: 32];
      if (absL(dr) > worst) begin worst = absL(dr); worstBin = k; end
      if (absL(di) > worst) begin worst = absL(di); worstBin = k; end
    end
    vectors++;
    if (e.tol == 0) begin
      assert (out === e.frame) else begin
        miscompares++;
        $error("[TB] FAIL %s: bin %0d out=%h expected=%h (error %0d LSB, exact required)",
               e.tag, worstBin, out[64*worstBin +: 64], e.frame[64*worstBin +: 64], worst);
      end
    end else begin
      assert (worst <= longint'(e.tol)) else begin
        miscompares++;
        $error("[TB] FAIL %s: bin %0d out=%h expected=%h (error %0d LSB, allowed %0d)",
               e.tag, worstBin, out[64*worstBin +: 64], e.frame[64*worstBin +: 64], worst, e.tol);
      end
    end
  endtask

  // A reset edge flushes everything in flight, so the 28 outputs from that edge on are all zero.
  task automatic applyStimulus(input logic [2047:0] frame, input logic rst,
                               input int tol, input string tag);
    sbEntry_t e;
    inp   = frame;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      scoreboard.delete();
      e.frame = '0;
      e.tol   = 0;
      e.tag   = "reset";
      repeat (28) scoreboard.push_back(e);
    end else begin
      e.frame = dftModel(frame);
      e.tol   = tol;
      e.tag   = tag;
      scoreboard.push_back(e);
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [2047:0] impulse, dc, tone, wrapFrame, f;
    reset = 1'b1;
    inp   = '0;
    impulse   = setSample('0, 0, 32'h00010000, 32'h0);
    tone      = setSample('0, 1, 32'h00010000, 32'h0);
    dc        = '0;
    wrapFrame = '0;
    for (int n = 0; n < 32; n++) begin
      dc        = setSample(dc, n, 32'h00010000, 32'h0);
      wrapFrame = setSample(wrapFrame, n, 32'h7FFF0000, 32'h0);
    end

    repeat (3) applyStimulus('0, 1'b1, 0, "reset");

    applyStimulus(impulse, 1'b0, 0, "impulse");
    applyStimulus(dc, 1'b0, 2, "dc");
    applyStimulus(tone, 1'b0, 4, "tone");
`ifndef BUTTERFLY_STAGE_SCALE_EN
    applyStimulus(wrapFrame, 1'b0, 0, "wrap");
`endif

    for (int i = 0; i < 4; i++) begin
      f = randFrame();
      repeat (5) applyStimulus(f, 1'b0, 24, "stream");
    end

    repeat (6) applyStimulus(randFrame(), 1'b0, 24, "preReset");
    applyStimulus(randFrame(), 1'b1, 0, "midReset");
    repeat (3) applyStimulus(randFrame(), 1'b0, 24, "postReset");
    applyStimulus(impulse, 1'b0, 0, "postResetImpulse");

    repeat (30) applyStimulus('0, 1'b0, 0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
